// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset sequencer: one FSM steps a shared ALU and unified memory
// through fetch/decode/execute/memory/writeback, with a memory-wait timeout and sticky trap.
module multicycle_ctrl #(
    parameter int CNT_W      = 16,
    parameter int WAIT_LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             regdst,
    output logic             mem2reg,
    output logic             alusrc_a,
    output logic [1:0]       alusrc_b,
    output logic             extop,
    output logic [3:0]       aluop,
    output logic [1:0]       pc_src,
    output logic [1:0]       swap,
    output logic             illegal,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_RSWP  = 6'b100000;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_ADDR, S_MEM_LW,
        S_WB_LW, S_MEM_SW, S_EXEC_BR, S_JUMP, S_SWAP1, S_SWAP2, S_TRAP
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, waitInc;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        cause_q, cause_d;
    logic              memState, timeout, retire;
    logic              funcLegal;
    logic [3:0]        funcAlu;

    always_comb begin
        funcLegal = 1'b1;
        funcAlu   = 4'b1111;
        case (func)
            6'b100000: funcAlu = 4'b0010;
            6'b100010: funcAlu = 4'b0110;
            6'b100100: funcAlu = 4'b0000;
            6'b100101: funcAlu = 4'b0001;
            6'b101010: funcAlu = 4'b0111;
            default:   funcLegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            count_q <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
            cause_q <= cause_d;
        end
    end

    // The wait counter only advances while a memory state is stalled; every other
    // cycle clears it, which also gives the clear-on-entry behaviour.
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        wait_d   = '0;
        retire   = 1'b0;
        timeout  = 1'b0;
        memState = (state_q == S_FETCH) || (state_q == S_MEM_LW) || (state_q == S_MEM_SW);
        waitInc  = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
        if (memState && !mem_ready) begin
            wait_d  = waitInc;
            timeout = (waitInc == WAIT_MAX);
        end

        case (state_q)
            S_IDLE:      if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) begin state_d = S_TRAP; cause_d = 2'b11; end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funcLegal) state_d = S_EXEC_R;
                        else begin state_d = S_TRAP; cause_d = 2'b10; end
                    end
                    OP_LW, OP_SW: state_d = S_EXEC_ADDR;
                    OP_BEQ:       state_d = S_EXEC_BR;
                    OP_J:         state_d = S_JUMP;
                    OP_RSWP:      state_d = S_SWAP1;
                    default: begin state_d = S_TRAP; cause_d = 2'b01; end
                endcase
            end
            S_EXEC_R:    state_d = S_WB_R;
            S_EXEC_ADDR: state_d = (opcode == OP_LW) ? S_MEM_LW : S_MEM_SW;
            S_MEM_LW: begin
                if (mem_ready)    state_d = S_WB_LW;
                else if (timeout) begin state_d = S_TRAP; cause_d = 2'b11; end
            end
            S_MEM_SW: begin
                if (mem_ready)    begin state_d = S_FETCH; retire = 1'b1; end
                else if (timeout) begin state_d = S_TRAP; cause_d = 2'b11; end
            end
            S_WB_R, S_WB_LW, S_EXEC_BR, S_JUMP, S_SWAP2: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_SWAP1:     state_d = S_SWAP2;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_IDLE;
        endcase

        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    // Moore decode; only pc_write/ir_write peek at zero and mem_ready.
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        regdst    = 1'b0;
        mem2reg   = 1'b0;
        alusrc_a  = 1'b0;
        alusrc_b  = 2'b00;
        extop     = 1'b0;
        aluop     = 4'b1111;
        pc_src    = 2'b00;
        swap      = 2'b00;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                alusrc_b = 2'b01;
                aluop    = 4'b0010;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: begin
                alusrc_b = 2'b11;
                extop    = 1'b1;
                aluop    = 4'b0010;
            end
            S_EXEC_R: begin
                alusrc_a = 1'b1;
                aluop    = funcAlu;
            end
            S_WB_R: begin
                regdst    = 1'b1;
                reg_write = 1'b1;
            end
            S_EXEC_ADDR: begin
                alusrc_a = 1'b1;
                alusrc_b = 2'b10;
                extop    = 1'b1;
                aluop    = 4'b0010;
            end
            S_MEM_LW: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_WB_LW: begin
                mem2reg   = 1'b1;
                reg_write = 1'b1;
            end
            S_MEM_SW: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_BR: begin
                alusrc_a = 1'b1;
                aluop    = 4'b0110;
                pc_src   = 2'b01;
                pc_write = zero;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            S_SWAP1: begin
                swap      = 2'b01;
                reg_write = 1'b1;
            end
            S_SWAP2: begin
                swap      = 2'b10;
                reg_write = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign trap_cause  = cause_q;
    assign instr_count = count_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath: the single-cycle decoder is replaced by an FSM that shares one ALU and one unified memory across fetch, decode, execute, memory and writeback cycles.
- Covers R-type (ADD/SUB/AND/OR/SLT), LW, SW, BEQ, J and the custom RSWP register swap.
- Handles a memory ready handshake with a timeout, a sticky trap, and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter instr_count.
- WAIT_LIMIT, 15, maximum number of mem_ready-low cycles tolerated in one memory state before a timeout trap.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  leave IDLE and begin fetching; sampled only in IDLE.
- opcode  input  6  IR[31:26], valid from DECODE onward.
- func  input  6  IR[5:0].
- zero  input  1  ALU zero flag, combinational.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  PC load enable.
- ir_write  output  1  IR load enable.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- reg_write  output  1  register bank write enable.
- regdst  output  1  write register select: 0=rt, 1=rd.
- mem2reg  output  1  write data select: 0=ALUOut, 1=MDR.
- alusrc_a  output  1  ALU A select: 0=PC, 1=reg A.
- alusrc_b  output  2  ALU B select: 00=reg B, 01=const 4, 10=ext imm, 11=ext imm<<2.
- extop  output  1  immediate extension: 1=sign, 0=zero.
- aluop  output  4  ALU function: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLT, 1111 none.
- pc_src  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- swap  output  2  RSWP phase: 00 off, 01 write A to rt, 10 write B to rs (overrides regdst and mem2reg).
- illegal  output  1  sticky trap flag.
- trap_cause  output  2  00 none, 01 bad opcode, 10 bad func, 11 memory timeout.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, while rst_n=0): state=IDLE, wait counter=0, instr_count=0, illegal=0, trap_cause=00. All strobes and selects are 0; aluop=1111. A reset mid-instruction drops strobes immediately.
- Output style: Moore decode of the state, except the mem_ready- and zero-qualified strobes noted below. Outputs not listed for a state are 0, aluop=1111.
- IDLE: no outputs asserted. Moves to FETCH when start=1.
- FETCH: iord=0, mem_read=1, alusrc_a=0, alusrc_b=01, aluop=0010, pc_src=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; moves to DECODE on mem_ready=1.
- DECODE: alusrc_a=0, alusrc_b=11, extop=1, aluop=0010 (precomputes branch target into ALUOut). Next state by opcode:
  - 000000 goes to EXEC_R if func is legal, else TRAP with cause 10.
  - 100011 and 101011 go to EXEC_ADDR.
  - 000100 goes to EXEC_BR.
  - 000010 goes to JUMP.
  - 100000 goes to SWAP1.
  - Any other opcode goes to TRAP with cause 01.
- EXEC_R: alusrc_a=1, alusrc_b=00, aluop decoded from func. Goes to WB_R.
- WB_R: regdst=1, mem2reg=0, reg_write=1. Retires, then FETCH.
- EXEC_ADDR: alusrc_a=1, alusrc_b=10, extop=1, aluop=0010. Goes to MEM_LW (opcode 100011) or MEM_SW (opcode 101011).
- MEM_LW: iord=1, mem_read=1. Waits for mem_ready, then WB_LW.
- WB_LW: regdst=0, mem2reg=1, reg_write=1. Retires, then FETCH.
- MEM_SW: iord=1, mem_write=1, held until mem_ready. Retires on mem_ready, then FETCH.
- EXEC_BR: alusrc_a=1, alusrc_b=00, aluop=0110, pc_src=01, pc_write=zero. Retires, then FETCH.
- JUMP: pc_src=10, pc_write=1. Retires, then FETCH.
- SWAP1: swap=01, reg_write=1. Goes to SWAP2.
- SWAP2: swap=10, reg_write=1. Retires, then FETCH.
  - A and B were latched in DECODE, so the second write uses the old rt value.
- Wait counter (FETCH, MEM_LW, MEM_SW):
  - Clears on entry to the state and on mem_ready=1.
  - Increments on each cycle with mem_ready=0.
  - If it reaches WAIT_LIMIT while mem_ready=0, the next state is TRAP with cause 11 and the strobe drops.
  - Counter saturates; it never wraps.
- TRAP: illegal=1, all strobes 0, trap_cause holds the first cause. Exits only via reset; start is ignored.
- Retire: instr_count increments by 1 on the last cycle of each instruction and wraps 2^CNT_W-1 to 0. A trapped instruction does not retire.
- Ignored inputs: start outside IDLE, and mem_ready outside FETCH/MEM states.
- CPI: R-type 4, LW 5, SW 4, BEQ 3, J 3, RSWP 4, each plus memory wait cycles.

Test Plan:
- Reset, then start=1 with mem_ready tied 1 and ADD (opcode 0, func 100000): states FETCH, DECODE, EXEC_R, WB_R. reg_write=1, regdst=1 in cycle 4; instr_count=1.
- LW with mem_ready low 3 cycles in MEM_LW: mem_read held 4 cycles, then WB_LW has mem2reg=1; total CPI 8.
- BEQ with zero=1, then with zero=0: pc_write=1 with pc_src=01 for zero=1; pc_write=0 for zero=0; both take 3 cycles.
- RSWP: swap=01, then swap=10, each with reg_write=1; instr_count advances by 1.
- Opcode 111111: TRAP, illegal=1, trap_cause=01, all strobes 0 for 20 cycles. Async rst_n pulse returns to IDLE with instr_count=0.
- mem_ready stuck 0 in FETCH with WAIT_LIMIT=15: TRAP with cause 11 after 15 wait cycles. Separately, instr_count preset path 0xFFFF plus one retire reads 0x0000.
